// File: rtl/instr_exec_scheduler.sv
// Instruction execution scheduler: queues received instruction words, clocks each one
// through the processor with a generated clock, then hands off to the regfile dumper.
module instr_exec_scheduler #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          PROC_CYCLES  = 5,
    parameter logic [31:0] NOOP         = 32'h13000000,
    parameter int          DUMP_TIMEOUT = 15
) (
    input  logic                        clk12,
    input  logic                        rst,
    input  logic [31:0]                 instr_in,
    input  logic                        instr_valid,
    input  logic                        dump_ready,
    output logic                        clk_proc,
    output logic [31:0]                 inst_out,
    output logic                        dump_start,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        dump_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(DUMP_TIMEOUT + 1);
    localparam logic [3:0]    LAST_CYC = 4'(PROC_CYCLES - 1);
    localparam logic [3:0]    CNT_ONE  = 4'd1;
    localparam logic [TW-1:0] LAST_TMO = TW'(DUMP_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_DUMP_REQ, S_DUMP_WAIT, S_DUMP_BUSY
    } state_t;

    state_t        r_state, w_next_state;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]   w_count;
    logic          w_full, w_push, w_pop;
    logic [31:0]   w_head;

    logic          r_clk_proc, w_clk_nxt;
    logic [31:0]   r_inst_out, w_inst_nxt;
    logic          r_dump_start, w_ds_nxt;
    logic          r_overflow, r_dump_err, w_err_set;
    logic [3:0]    r_cycle_cnt, w_cnt_nxt;
    logic [TW-1:0] r_tmo_cnt, w_tmo_nxt;
    logic [31:0]   r_cur_instr, w_cur_nxt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == FULL_CNT);
    assign w_push  = instr_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && (w_count != '0) && dump_ready;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk12) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= instr_in;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk12) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_pop) w_next_state = S_EXEC;
            S_EXEC:      if (r_clk_proc && r_cycle_cnt == LAST_CYC) w_next_state = S_DUMP_REQ;
            S_DUMP_REQ:  w_next_state = S_DUMP_WAIT;
            S_DUMP_WAIT: begin
                if (!dump_ready)                 w_next_state = S_DUMP_BUSY;
                else if (r_tmo_cnt == LAST_TMO)  w_next_state = S_IDLE;
            end
            S_DUMP_BUSY: if (dump_ready) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; inst_out is registered so the word is
    // already stable when the first clk_proc rising edge arrives.
    always_comb begin
        w_clk_nxt = 1'b1;
        w_cnt_nxt = r_cycle_cnt;
        w_tmo_nxt = r_tmo_cnt;
        w_cur_nxt = r_cur_instr;
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: if (w_pop) begin
                w_clk_nxt = 1'b0;
                w_cnt_nxt = '0;
                w_cur_nxt = w_head;
            end
            S_EXEC: if (w_next_state == S_EXEC) begin
                w_clk_nxt = ~r_clk_proc;
                if (r_clk_proc) w_cnt_nxt = r_cycle_cnt + CNT_ONE;
            end
            S_DUMP_REQ: w_tmo_nxt = '0;
            S_DUMP_WAIT: if (dump_ready) begin
                if (r_tmo_cnt == LAST_TMO) w_err_set = 1'b1;
                else                       w_tmo_nxt = r_tmo_cnt + TMO_ONE;
            end
            default: ;
        endcase
        w_inst_nxt = (w_next_state == S_EXEC && w_cnt_nxt == '0) ? w_cur_nxt : NOOP;
        w_ds_nxt   = (w_next_state == S_DUMP_REQ);
    end

    always_ff @(posedge clk12) begin
        if (rst) begin
            r_clk_proc   <= 1'b1;
            r_inst_out   <= NOOP;
            r_dump_start <= 1'b0;
            r_overflow   <= 1'b0;
            r_dump_err   <= 1'b0;
            r_cycle_cnt  <= '0;
            r_tmo_cnt    <= '0;
            r_cur_instr  <= NOOP;
        end else begin
            r_clk_proc   <= w_clk_nxt;
            r_inst_out   <= w_inst_nxt;
            r_dump_start <= w_ds_nxt;
            r_overflow   <= r_overflow | (instr_valid & w_full);
            r_dump_err   <= r_dump_err | w_err_set;
            r_cycle_cnt  <= w_cnt_nxt;
            r_tmo_cnt    <= w_tmo_nxt;
            r_cur_instr  <= w_cur_nxt;
        end
    end

    assign clk_proc   = r_clk_proc;
    assign inst_out   = r_inst_out;
    assign dump_start = r_dump_start;
    assign overflow   = r_overflow;
    assign dump_err   = r_dump_err;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = w_count;
endmodule

// File: tb/tb_instr_exec_scheduler.sv
// Bench for instr_exec_scheduler: two instances (PROC_CYCLES 5 and 1) share one stimulus
// and are checked every cycle against a job-timeline model plus hand-computed expectations.
module tb_instr_exec_scheduler;
    localparam logic [31:0] NOOP = 32'h13000000;
    localparam int          TMO  = 15;

    logic        clk12 = 1'b0;
    logic        rst = 1'b1, instr_valid = 1'b0, dump_ready = 1'b1;
    logic [31:0] instr_in = '0;

    logic        co_clk [2];
    logic [31:0] co_inst [2];
    logic        co_ds [2], co_busy [2], co_ovf [2], co_err [2];
    logic [2:0]  co_cnt [2];

    int checks = 0, failures = 0;
    bit started = 1'b0;

    always #5 clk12 = ~clk12;

    instr_exec_scheduler #(.PROC_CYCLES(5)) u_dut5 (
        .clk12(clk12), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .dump_ready(dump_ready), .clk_proc(co_clk[0]), .inst_out(co_inst[0]),
        .dump_start(co_ds[0]), .busy(co_busy[0]), .fifo_count(co_cnt[0]),
        .overflow(co_ovf[0]), .dump_err(co_err[0]));

    instr_exec_scheduler #(.PROC_CYCLES(1)) u_dut1 (
        .clk12(clk12), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .dump_ready(dump_ready), .clk_proc(co_clk[1]), .inst_out(co_inst[1]),
        .dump_start(co_ds[1]), .busy(co_busy[1]), .fifo_count(co_cnt[1]),
        .overflow(co_ovf[1]), .dump_err(co_err[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: a queue plus a per-job timeline. mode 0 idle, 1 job running (k = cycles since
    // pop; k<2P executing, k==2P dump request), 2 waiting for dump_ready low, 3 dump busy.
    int          m_p [2] = '{5, 1};
    logic [31:0] m_q [2][8];
    int          m_n [2], m_mode [2], m_k [2], m_w [2];
    logic [31:0] m_cur [2];
    bit          m_ovf [2], m_err [2];

    task automatic model_step(input int d);
        logic [31:0] head;
        bit          pop;
        int          pre_n;
        if (rst) begin
            m_n[d] = 0; m_mode[d] = 0; m_k[d] = 0; m_w[d] = 0; m_ovf[d] = 0; m_err[d] = 0;
            return;
        end
        pre_n = m_n[d];
        pop   = (m_mode[d] == 0) && (pre_n > 0) && dump_ready;
        head  = m_q[d][0];
        if (pop) begin
            for (int i = 0; i < 7; i++) m_q[d][i] = m_q[d][i+1];
            m_n[d]--;
        end
        if (instr_valid) begin
            if (pre_n < 4) begin m_q[d][m_n[d]] = instr_in; m_n[d]++; end
            else m_ovf[d] = 1;
        end
        case (m_mode[d])
            0: if (pop) begin m_mode[d] = 1; m_k[d] = 0; m_cur[d] = head; end
            1: begin
                m_k[d]++;
                if (m_k[d] > 2 * m_p[d]) begin m_mode[d] = 2; m_w[d] = 0; end
            end
            2: if (!dump_ready) m_mode[d] = 3;
               else begin
                   m_w[d]++;
                   if (m_w[d] == TMO) begin m_mode[d] = 0; m_err[d] = 1; end
               end
            default: if (dump_ready) m_mode[d] = 0;
        endcase
    endtask

    always @(posedge clk12) for (int d = 0; d < 2; d++) model_step(d);

    int          edges [2], icyc [2], dsn [2], lc [2];
    logic [31:0] lg [2][8];
    logic        prev_clk [2];
    logic [31:0] prev_inst [2];

    always @(negedge clk12) if (started) begin
        for (int d = 0; d < 2; d++) begin
            logic        e_clk;
            logic [31:0] e_inst;
            e_clk  = (m_mode[d] == 1 && m_k[d] < 2 * m_p[d]) ? (m_k[d] % 2 == 1) : 1'b1;
            e_inst = (m_mode[d] == 1 && m_k[d] < 2) ? m_cur[d] : NOOP;
            chk($sformatf("dut%0d clk_proc", d),   32'(co_clk[d]),  32'(e_clk));
            chk($sformatf("dut%0d inst_out", d),   co_inst[d],      e_inst);
            chk($sformatf("dut%0d dump_start", d), 32'(co_ds[d]),   32'(m_mode[d] == 1 && m_k[d] == 2 * m_p[d]));
            chk($sformatf("dut%0d busy", d),       32'(co_busy[d]), 32'(m_mode[d] != 0));
            chk($sformatf("dut%0d fifo_count", d), 32'(co_cnt[d]),  32'(m_n[d]));
            chk($sformatf("dut%0d overflow", d),   32'(co_ovf[d]),  32'(m_ovf[d]));
            chk($sformatf("dut%0d dump_err", d),   32'(co_err[d]),  32'(m_err[d]));
            if (!prev_clk[d] && co_clk[d]) edges[d]++;
            if (co_inst[d] != NOOP) begin
                icyc[d]++;
                if (prev_inst[d] == NOOP && lc[d] < 8) begin lg[d][lc[d]] = co_inst[d]; lc[d]++; end
            end
            if (co_ds[d]) dsn[d]++;
            prev_clk[d]  = co_clk[d];
            prev_inst[d] = co_inst[d];
        end
    end

    task automatic tick(); @(negedge clk12); #1; endtask

    task automatic push(input logic [31:0] w);
        instr_in = w; instr_valid = 1'b1; tick(); instr_valid = 1'b0;
    endtask

    task automatic clr();
        for (int d = 0; d < 2; d++) begin edges[d] = 0; icyc[d] = 0; dsn[d] = 0; lc[d] = 0; end
    endtask

    task automatic wait_ds(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (co_ds[0]) begin ok = 1'b1; return; end
        end
        checks++; failures++;
        $display("FAIL dump_start_wait got=none required=pulse within 80 cycles");
    endtask

    // Dumper handshake as seen by DUT0: drop ready 2 cycles after dump_start, hold, raise.
    task automatic do_dump(input int hold);
        bit ok;
        wait_ds(ok);
        if (!ok) return;
        tick(); tick();
        dump_ready = 1'b0;
        repeat (hold) tick();
        chk("busy_in_dump", 32'(co_busy[0]), 32'd1);
        dump_ready = 1'b1;
        tick();
        chk("busy_after_ready", 32'(co_busy[0]), 32'd0);
    endtask

    task automatic chk_log(input int d, input int n, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        chk($sformatf("dut%0d exec_count", d), 32'(lc[d]), 32'(n));
        for (int i = 0; i < n; i++) chk($sformatf("dut%0d exec_order%0d", d, i), lg[d][i], w[i]);
    endtask

    initial begin
        logic [31:0] wv [6];
        bit ok;
        wv = '{32'h00100113, 32'h00200193, 32'h00300213, 32'h00400293, 32'h00500313, 32'h00600393};
        for (int d = 0; d < 2; d++) begin prev_clk[d] = 1'b1; prev_inst[d] = NOOP; end
        clr();

        // Reset
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst dut%0d clk_proc", d), 32'(co_clk[d]), 32'd1);
            chk($sformatf("rst dut%0d inst_out", d), co_inst[d], NOOP);
            chk($sformatf("rst dut%0d busy", d), 32'(co_busy[d]), 32'd0);
            chk($sformatf("rst dut%0d fifo_count", d), 32'(co_cnt[d]), 32'd0);
        end

        // Single instruction, full dump handshake
        clr();
        push(32'h00500093);
        do_dump(10);
        repeat (3) tick();
        chk("t1 dut5 rising_edges", 32'(edges[0]), 32'd5);
        chk("t1 dut1 rising_edges", 32'(edges[1]), 32'd1);
        chk("t1 dut5 instr_cycles", 32'(icyc[0]), 32'd2);
        chk("t1 dut1 instr_cycles", 32'(icyc[1]), 32'd2);
        chk("t1 dut5 dump_starts",  32'(dsn[0]),  32'd1);
        chk("t1 dut1 dump_starts",  32'(dsn[1]),  32'd1);
        chk_log(0, 1, 32'h00500093, 0, 0, 0);

        // Overflow: six pushes into a stalled queue
        dump_ready = 1'b0;
        clr();
        for (int i = 0; i < 6; i++) push(wv[i]);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t2 dut%0d fifo_sat", d), 32'(co_cnt[d]), 32'd4);
            chk($sformatf("t2 dut%0d overflow", d), 32'(co_ovf[d]), 32'd1);
        end
        dump_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_dump(3);
        repeat (3) tick();
        chk_log(0, 4, wv[0], wv[1], wv[2], wv[3]);
        chk_log(1, 4, wv[0], wv[1], wv[2], wv[3]);

        // Simultaneous push and pop with one word queued
        dump_ready = 1'b0;
        clr();
        push(32'hA0A0A0A1);
        instr_in = 32'hB0B0B0B2; instr_valid = 1'b1; dump_ready = 1'b1;
        tick();
        instr_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t3 dut%0d count_hold", d), 32'(co_cnt[d]), 32'd1);
            chk($sformatf("t3 dut%0d busy", d), 32'(co_busy[d]), 32'd1);
        end
        do_dump(3);
        do_dump(3);
        repeat (3) tick();
        chk_log(0, 2, 32'hA0A0A0A1, 32'hB0B0B0B2, 0, 0);
        chk_log(1, 2, 32'hA0A0A0A1, 32'hB0B0B0B2, 0, 0);

        // Dump timeout with a second word waiting
        clr();
        push(32'hC0C0C0C3);
        push(32'hD0D0D0D4);
        wait_ds(ok);
        if (ok) begin
            repeat (15) tick();
            chk("t4 err_before", 32'(co_err[0]), 32'd0);
            chk("t4 busy_before", 32'(co_busy[0]), 32'd1);
            tick();
            chk("t4 err_after", 32'(co_err[0]), 32'd1);
            chk("t4 busy_after", 32'(co_busy[0]), 32'd0);
        end
        do_dump(3);
        repeat (3) tick();
        chk("t4 dut1 err", 32'(co_err[1]), 32'd1);
        chk_log(0, 2, 32'hC0C0C0C3, 32'hD0D0D0D4, 0, 0);
        chk_log(1, 2, 32'hC0C0C0C3, 32'hD0D0D0D4, 0, 0);

        // Reset at the third clk_proc rising edge with two words still queued
        dump_ready = 1'b0;
        push(32'hE0E0E0E5);
        push(32'hF0F0F0F6);
        push(32'h0A0A0A07);
        clr();
        dump_ready = 1'b1;
        for (int n = 0; n < 40 && edges[0] < 3; n++) tick();
        chk("t5 edge3_reached", 32'(edges[0]), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t5 dut%0d clk_proc", d), 32'(co_clk[d]), 32'd1);
            chk($sformatf("t5 dut%0d fifo_count", d), 32'(co_cnt[d]), 32'd0);
            chk($sformatf("t5 dut%0d inst_out", d), co_inst[d], NOOP);
            chk($sformatf("t5 dut%0d busy", d), 32'(co_busy[d]), 32'd0);
            chk($sformatf("t5 dut%0d dump_err", d), 32'(co_err[d]), 32'd0);
        end
        clr();
        repeat (20) tick();
        chk("t5 dut5 no_dump", 32'(dsn[0]), 32'd0);
        chk("t5 dut1 no_dump", 32'(dsn[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
